// File: rtl/dc_pred_accum.sv
// DC intra-prediction accumulator: sums four left and four top neighbour pixels
// streamed from RAM after a block preset, then emits one rounded DC value.
module dc_pred_accum (
   input  logic       CLK_HIGH,
   input  logic       RST_n,
   input  logic       preset_flag,
   input  logic       EN_LEFT,
   input  logic       EN_TOP,
   input  logic       AVAIL_LEFT,
   input  logic       AVAIL_TOP,
   input  logic [7:0] DATA_IN,
   output logic [7:0] DC_OUT,
   output logic       DC_VALID,
   output logic       BUSY
);

   typedef enum logic [1:0] {S_IDLE, S_LEFT, S_TOP, S_OUT} state_t;

   state_t     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic [9:0] sum_left_q, sum_left_d;
   logic [9:0] sum_top_q, sum_top_d;
   logic       avail_left_q, avail_left_d;
   logic       avail_top_q, avail_top_d;
   logic       en_left_d_q, en_top_d_q;
   logic [7:0] dc_out_q, dc_out_d;
   logic       dc_valid_q, dc_valid_d;
   logic       busy_q, busy_d;
   logic       cap_left, cap_top;

   function automatic logic [7:0] avg8_rnd(input logic [9:0] a, input logic [9:0] b);
      logic [10:0] s;
      s = {1'b0, a} + {1'b0, b} + 11'd4;
      return 8'(s >> 3);
   endfunction

   function automatic logic [7:0] avg4_rnd(input logic [9:0] a);
      logic [10:0] s;
      s = {1'b0, a} + 11'd2;
      return 8'(s >> 2);
   endfunction

   function automatic logic [7:0] dc_calc(input logic al, input logic at,
                                          input logic [9:0] sl, input logic [9:0] st);
      logic [7:0] r;
      case ({al, at})
         2'b11:   r = avg8_rnd(sl, st);
         2'b10:   r = avg4_rnd(sl);
         2'b01:   r = avg4_rnd(st);
         default: r = 8'd128;
      endcase
      return r;
   endfunction

   // The enable flags are delayed one edge so they line up with the RAM read data.
   assign cap_left = (state_q == S_LEFT) && en_left_d_q;
   assign cap_top  = (state_q == S_TOP)  && en_top_d_q;

   always_ff @(posedge CLK_HIGH or negedge RST_n) begin
      if (!RST_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= 2'd0;
         sum_left_q   <= 10'd0;
         sum_top_q    <= 10'd0;
         avail_left_q <= 1'b0;
         avail_top_q  <= 1'b0;
         en_left_d_q  <= 1'b0;
         en_top_d_q   <= 1'b0;
         dc_out_q     <= 8'd0;
         dc_valid_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sum_left_q   <= sum_left_d;
         sum_top_q    <= sum_top_d;
         avail_left_q <= avail_left_d;
         avail_top_q  <= avail_top_d;
         en_left_d_q  <= EN_LEFT;
         en_top_d_q   <= EN_TOP;
         dc_out_q     <= dc_out_d;
         dc_valid_q   <= dc_valid_d;
         busy_q       <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (preset_flag) begin
         state_d = S_LEFT;
      end else begin
         case (state_q)
            S_LEFT:  if (cap_left && (cnt_q == 2'd3)) state_d = S_TOP;
            S_TOP:   if (cap_top  && (cnt_q == 2'd3)) state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // A preset always restarts the block, including on the OUT edge.
   always_comb begin
      cnt_d        = cnt_q;
      sum_left_d   = sum_left_q;
      sum_top_d    = sum_top_q;
      avail_left_d = avail_left_q;
      avail_top_d  = avail_top_q;
      dc_out_d     = dc_out_q;
      dc_valid_d   = 1'b0;
      busy_d       = busy_q;
      if (preset_flag) begin
         cnt_d        = 2'd0;
         sum_left_d   = 10'd0;
         sum_top_d    = 10'd0;
         avail_left_d = AVAIL_LEFT;
         avail_top_d  = AVAIL_TOP;
         busy_d       = 1'b1;
      end else begin
         case (state_q)
            S_LEFT: begin
               if (cap_left) begin
                  sum_left_d = sum_left_q + {2'b00, DATA_IN};
                  cnt_d      = cnt_q + 2'd1;
               end
            end
            S_TOP: begin
               if (cap_top) begin
                  sum_top_d = sum_top_q + {2'b00, DATA_IN};
                  cnt_d     = cnt_q + 2'd1;
               end
            end
            S_OUT: begin
               dc_out_d   = dc_calc(avail_left_q, avail_top_q, sum_left_q, sum_top_q);
               dc_valid_d = 1'b1;
               busy_d     = 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign DC_OUT   = dc_out_q;
   assign DC_VALID = dc_valid_q;
   assign BUSY     = busy_q;

endmodule

// File: tb/tb_dc_pred_accum.sv
// Bench for dc_pred_accum: a per-edge stimulus schedule emulating the address
// arbiter, checked against a timeline model plus directed expectations.
module tb_dc_pred_accum;

   logic       CLK_HIGH = 1'b0;
   logic       RST_n;
   logic       preset_flag, EN_LEFT, EN_TOP, AVAIL_LEFT, AVAIL_TOP;
   logic [7:0] DATA_IN;
   logic [7:0] DC_OUT;
   logic       DC_VALID, BUSY;

   dc_pred_accum dut (
      .CLK_HIGH    (CLK_HIGH),
      .RST_n       (RST_n),
      .preset_flag (preset_flag),
      .EN_LEFT     (EN_LEFT),
      .EN_TOP      (EN_TOP),
      .AVAIL_LEFT  (AVAIL_LEFT),
      .AVAIL_TOP   (AVAIL_TOP),
      .DATA_IN     (DATA_IN),
      .DC_OUT      (DC_OUT),
      .DC_VALID    (DC_VALID),
      .BUSY        (BUSY)
   );

   always #5 CLK_HIGH = ~CLK_HIGH;

   typedef struct {
      bit         pf;
      bit         rst;
      bit         el;
      bit         et;
      bit         al;
      bit         at;
      logic [7:0] d;
   } edge_t;

   typedef struct {
      int         e;
      bit         v;
      logic [7:0] val;
      bit         chkval;
   } dchk_t;

   typedef struct {
      bit              al;
      bit              at;
      logic [3:0][7:0] l;
      logic [3:0][7:0] t;
      logic [7:0]      exp;
   } vec_t;

   edge_t      sch[$];
   dchk_t      dchk[$];
   bit         exp_v[$];
   bit         exp_b[$];
   logic [7:0] exp_o[$];
   vec_t       vecs[9];

   int checks   = 0;
   int failures = 0;

   function automatic logic [7:0] rnd8();
      return 8'($urandom);
   endfunction

   function automatic logic [3:0][7:0] rep4(input logic [7:0] x);
      return {4{x}};
   endfunction

   function automatic logic [3:0][7:0] rnd4();
      return {rnd8(), rnd8(), rnd8(), rnd8()};
   endfunction

   task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s edge=%0d got=%0d want=%0d", name, n, act, exp);
      end
   endtask

   task automatic add_edge(input bit pf, input bit rst, input bit el, input bit et, input logic [7:0] d);
      edge_t e;
      e.pf  = pf;
      e.rst = rst;
      e.el  = el;
      e.et  = et;
      e.al  = 1'($urandom_range(0, 1));
      e.at  = 1'($urandom_range(0, 1));
      e.d   = d;
      sch.push_back(e);
   endtask

   // Preset edge followed by nafter edges of arbiter activity for that block.
   task automatic add_block(input bit al, input bit at, input logic [3:0][7:0] l,
                            input logic [3:0][7:0] t, input int nafter, input bit hold,
                            output int p);
      logic [7:0] d;
      p = sch.size();
      add_edge(1'b1, 1'b0, 1'b0, 1'b0, rnd8());
      sch[p].al = al;
      sch[p].at = at;
      for (int k = 1; k <= nafter; k++) begin
         d = rnd8();
         if (k >= 2 && k <= 5)      d = l[k-2];
         else if (k >= 6 && k <= 9) d = t[k-6];
         add_edge(1'b0, 1'b0, k <= 4, (k >= 5 && k <= 8) || (hold && k >= 9), d);
      end
   endtask

   task automatic add_idle(input int n, input bit hold);
      for (int k = 0; k < n; k++)
         add_edge(1'b0, 1'b0, hold ? 1'b0 : 1'($urandom_range(0, 1)),
                  hold ? 1'b1 : 1'($urandom_range(0, 1)), rnd8());
   endtask

   function automatic logic [7:0] ref_dc(input int p);
      int sl = 0;
      int st = 0;
      for (int i = 0; i < 4; i++) begin
         sl += int'(sch[p+2+i].d);
         st += int'(sch[p+6+i].d);
      end
      if (sch[p].al && sch[p].at) return 8'((sl + st + 4) / 8);
      if (sch[p].al)              return 8'((sl + 2) / 4);
      if (sch[p].at)              return 8'((st + 2) / 4);
      return 8'd128;
   endfunction

   // Timeline model: a block started at edge p reports at edge p+10 unless a
   // preset or reset intervenes; BUSY covers edges p..p+9.
   task automatic build_model();
      int         p;
      logic [7:0] cur;
      bit         v, b;
      p   = -1;
      cur = 8'd0;
      for (int n = 0; n < sch.size(); n++) begin
         v = 1'b0;
         b = 1'b0;
         if (sch[n].rst) begin
            p   = -1;
            cur = 8'd0;
         end else if (sch[n].pf) begin
            p = n;
            b = 1'b1;
         end else if (p >= 0) begin
            if (n - p < 10) b = 1'b1;
            else begin
               v   = 1'b1;
               cur = ref_dc(p);
               p   = -1;
            end
         end
         exp_v.push_back(v);
         exp_b.push_back(b);
         exp_o.push_back(cur);
      end
   endtask

   task automatic expect_at(input int e, input bit v, input logic [7:0] val, input bit chkval);
      dchk_t c;
      c.e = e; c.v = v; c.val = val; c.chkval = chkval;
      dchk.push_back(c);
   endtask

   initial begin
      int p, p2, r, na;
      bit al, at;

      vecs[0] = '{al:1, at:1, l:rep4(8'd10), t:rep4(8'd20), exp:8'd15};
      vecs[1] = '{al:1, at:0, l:{8'd13, 8'd12, 8'd11, 8'd10}, t:rep4(8'd255), exp:8'd12};
      vecs[2] = '{al:0, at:1, l:rep4(8'd99), t:rep4(8'd7), exp:8'd7};
      vecs[3] = '{al:0, at:0, l:rep4(8'd200), t:rep4(8'd3), exp:8'd128};
      vecs[4] = '{al:1, at:1, l:rep4(8'd255), t:rep4(8'd255), exp:8'd255};
      vecs[5] = '{al:1, at:0, l:{8'd0, 8'd0, 8'd0, 8'd1}, t:rep4(8'd90), exp:8'd0};
      vecs[6] = '{al:1, at:0, l:{8'd0, 8'd0, 8'd1, 8'd1}, t:rep4(8'd90), exp:8'd1};
      vecs[7] = '{al:1, at:1, l:{8'd0, 8'd0, 8'd0, 8'd4}, t:rep4(8'd0), exp:8'd1};
      vecs[8] = '{al:0, at:1, l:rep4(8'd77), t:{8'd5, 8'd0, 8'd0, 8'd0}, exp:8'd1};

      add_idle(3, 1'b0);
      for (int i = 0; i < 9; i++) begin
         add_block(vecs[i].al, vecs[i].at, vecs[i].l, vecs[i].t, 10, 1'b0, p);
         expect_at(p + 10, 1'b1, vecs[i].exp, 1'b1);
         expect_at(p + 11, 1'b0, 8'd0, 1'b0);
         add_idle(2, 1'b0);
      end

      // Second preset at E5 aborts the first block.
      add_block(1'b1, 1'b1, rep4(8'd50), rep4(8'd60), 4, 1'b0, p);
      add_block(1'b1, 1'b1, rep4(8'd8), rep4(8'd16), 10, 1'b0, p2);
      expect_at(p + 10, 1'b0, 8'd0, 1'b0);
      expect_at(p + 15, 1'b1, 8'd12, 1'b1);
      add_idle(3, 1'b0);

      // Preset landing on the OUT edge wins.
      add_block(1'b1, 1'b1, rep4(8'd100), rep4(8'd100), 9, 1'b0, p);
      add_block(1'b1, 1'b0, rep4(8'd40), rep4(8'd1), 10, 1'b0, p2);
      expect_at(p + 10, 1'b0, 8'd0, 1'b0);
      expect_at(p2 + 10, 1'b1, 8'd40, 1'b1);
      add_idle(3, 1'b0);

      // Reset at E6 then EN_TOP stuck high: nothing may be reported.
      add_block(1'b1, 1'b1, rep4(8'd9), rep4(8'd9), 5, 1'b0, p);
      add_edge(1'b0, 1'b1, 1'b0, 1'b1, rnd8());
      expect_at(p + 6, 1'b0, 8'd0, 1'b1);
      add_idle(14, 1'b1);
      for (int k = 7; k <= 20; k++) expect_at(p + k, 1'b0, 8'd0, 1'b1);

      // EN_TOP held high after a full block gives exactly one report.
      add_block(1'b0, 1'b1, rep4(8'd1), rep4(8'd30), 10, 1'b1, p);
      add_idle(15, 1'b1);
      expect_at(p + 10, 1'b1, 8'd30, 1'b1);
      for (int k = 11; k <= 25; k++) expect_at(p + k, 1'b0, 8'd30, 1'b1);

      for (int i = 0; i < 60; i++) begin
         al = 1'($urandom_range(0, 1));
         at = 1'($urandom_range(0, 1));
         r  = $urandom_range(0, 9);
         if (r == 0) begin
            na = $urandom_range(1, 9);
            add_block(al, at, rnd4(), rnd4(), na, 1'b0, p);
         end else if (r == 1) begin
            na = $urandom_range(1, 10);
            add_block(al, at, rnd4(), rnd4(), na, 1'b0, p);
            add_edge(1'b0, 1'b1, 1'b0, 1'b0, rnd8());
            add_idle($urandom_range(0, 3), 1'b0);
         end else begin
            add_block(al, at, rnd4(), rnd4(), 10, 1'b0, p);
            add_idle($urandom_range(0, 4), 1'($urandom_range(0, 1)));
         end
      end
      add_idle(12, 1'b0);

      build_model();

      RST_n = 1'b1; preset_flag = 1'b0; EN_LEFT = 1'b0; EN_TOP = 1'b0;
      AVAIL_LEFT = 1'b0; AVAIL_TOP = 1'b0; DATA_IN = 8'd0;
      #2 RST_n = 1'b0;
      #2;
      chk("rst_dc_out", -1, 32'(DC_OUT), 32'd0);
      chk("rst_valid",  -1, 32'(DC_VALID), 32'd0);
      chk("rst_busy",   -1, 32'(BUSY), 32'd0);
      preset_flag = 1'b1; EN_LEFT = 1'b1; EN_TOP = 1'b1; DATA_IN = 8'hff;
      repeat (2) @(posedge CLK_HIGH);
      #1;
      chk("rst_hold_busy",  -1, 32'(BUSY), 32'd0);
      chk("rst_hold_valid", -1, 32'(DC_VALID), 32'd0);
      preset_flag = 1'b0; EN_LEFT = 1'b0; EN_TOP = 1'b0;
      RST_n = 1'b1;
      @(posedge CLK_HIGH);
      #1;
      chk("idle_busy", -1, 32'(BUSY), 32'd0);

      for (int n = 0; n < sch.size(); n++) begin
         preset_flag = sch[n].pf;
         EN_LEFT     = sch[n].el;
         EN_TOP      = sch[n].et;
         AVAIL_LEFT  = sch[n].al;
         AVAIL_TOP   = sch[n].at;
         DATA_IN     = sch[n].d;
         if (sch[n].rst) begin
            RST_n = 1'b0;
            #1;
            chk("async_rst_out",   n, 32'(DC_OUT), 32'd0);
            chk("async_rst_valid", n, 32'(DC_VALID), 32'd0);
            chk("async_rst_busy",  n, 32'(BUSY), 32'd0);
         end
         @(posedge CLK_HIGH);
         #1;
         chk("dc_valid", n, 32'(DC_VALID), 32'(exp_v[n]));
         chk("busy",     n, 32'(BUSY), 32'(exp_b[n]));
         chk("dc_out",   n, 32'(DC_OUT), 32'(exp_o[n]));
         foreach (dchk[i]) begin
            if (dchk[i].e == n) begin
               chk("directed_valid", n, 32'(DC_VALID), 32'(dchk[i].v));
               if (dchk[i].chkval) chk("directed_out", n, 32'(DC_OUT), 32'(dchk[i].val));
            end
         end
         RST_n = 1'b1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dc_pred_accum.md
DC_PRED_ACCUM -- requirements
Module: dc_pred_accum

Interface
REQ-001 SHALL have port CLK_HIGH  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port RST_n  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port preset_flag  input  1  start-of-block pulse, same signal that drives the address arbiter.
REQ-004 SHALL have port EN_LEFT  input  1  arbiter flag; address on the bus is a left-neighbour read.
REQ-005 SHALL have port EN_TOP  input  1  arbiter flag; address on the bus is a top-neighbour read.
REQ-006 SHALL have port AVAIL_LEFT  input  1  left neighbours usable; sampled when preset_flag=1.
REQ-007 SHALL have port AVAIL_TOP  input  1  top neighbours usable; sampled when preset_flag=1.
REQ-008 SHALL have port DATA_IN  input  8  neighbour pixel from synchronous RAM, one cycle after the address.
REQ-009 SHALL have port DC_OUT  output  8  registered DC prediction value.
REQ-010 SHALL have port DC_VALID  output  1  one-cycle pulse; DC_OUT is valid.
REQ-011 SHALL have port BUSY  output  1  high from preset acceptance until DC_VALID.

Function
REQ-012 SHALL register EN_LEFT and EN_TOP once (en_left_d, en_top_d) so that the flags align with DATA_IN.
REQ-013 SHALL implement states IDLE, LEFT, TOP, OUT.
REQ-014 On preset_flag=1 (any state), SHALL enter LEFT, clear both sums and the sample counter, latch AVAIL_LEFT/AVAIL_TOP, and set BUSY=1.
REQ-015 In LEFT, SHALL add DATA_IN to sum_left (10 bit) on each edge with en_left_d=1, counting 0..3.
REQ-016 After the 4th left sample, SHALL enter TOP with the counter cleared.
REQ-017 In TOP, SHALL add DATA_IN to sum_top (10 bit) on each edge with en_top_d=1, counting 0..3.
REQ-018 After the 4th top sample, SHALL enter OUT.
REQ-019 Once 4 top samples are counted, SHALL ignore further EN_TOP=1 cycles, because the arbiter holds EN_TOP high.
REQ-020 In OUT, SHALL compute DC_OUT in one edge, then pulse DC_VALID=1 for exactly one cycle, clear BUSY and return to IDLE.
REQ-021 If both latched availabilities are 1, SHALL set DC_OUT = (sum_left + sum_top + 4) >> 3, using an 11-bit intermediate.
REQ-022 If only the left availability is 1, SHALL set DC_OUT = (sum_left + 2) >> 2.
REQ-023 If only the top availability is 1, SHALL set DC_OUT = (sum_top + 2) >> 2.
REQ-024 If neither availability is 1, SHALL set DC_OUT = 8'd128.
REQ-025 SHALL always collect all 8 samples regardless of availability, so latency is fixed.
REQ-026 Latency: if preset_flag is sampled at edge E0, captures SHALL occur at E2..E9 and DC_VALID SHALL be high in the cycle after E10.
REQ-027 A preset_flag during LEFT, TOP or OUT SHALL abort the current block with no DC_VALID for it and restart per REQ-014.
REQ-028 A preset_flag coincident with the OUT edge SHALL take priority and suppress that block's DC_VALID.
REQ-029 In IDLE, EN_LEFT, EN_TOP and DATA_IN SHALL be ignored.
REQ-030 DC_OUT SHALL hold its last value until the next OUT computation.

Reset
REQ-031 On RST_n=0, SHALL immediately set state=IDLE, DC_OUT=0, DC_VALID=0, BUSY=0, both sums=0, counter=0, en_left_d=0, en_top_d=0 and latched availabilities=0.
REQ-032 Reset mid-block SHALL discard the block; after release, no DC_VALID SHALL occur until a new preset_flag.

Verification
REQ-033 Both available, left samples all 10, top samples all 20 -> DC_OUT=15, DC_VALID one cycle, 10 edges after preset.
REQ-034 Left only, left samples 10,11,12,13 and top samples 255 -> DC_OUT=12; top only, top samples all 7 -> DC_OUT=7.
REQ-035 Neither available, arbitrary data -> DC_OUT=128; both available with all samples 255 -> DC_OUT=255 (no overflow).
REQ-036 Second preset_flag at E5 -> no DC_VALID at E10; single DC_VALID at E15 with the second block's value.
REQ-037 RST_n low at E6 then released -> all outputs 0, BUSY=0 and no DC_VALID until the next preset_flag; EN_TOP held high indefinitely after a block -> only one DC_VALID.
